// File: rtl/gcd_stein_ctrl.sv
// Iterative binary (Stein) GCD engine for unsigned WIDTH-bit operands.
// A single shared trailing-zero counter strips each power-of-two factor in one cycle.

module find_first_one #(
  parameter int WIDTH = 32,
  parameter bit FLIP  = 1'b0
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] first_one_o,
  output logic                     no_ones_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] scan;

  // FLIP=0 scans from bit 0 upward, so the result is the trailing-zero count.
  always_comb begin
    scan = '0;
    for (int i = 0; i < WIDTH; i++) begin
      scan[i] = FLIP ? in_i[WIDTH-1-i] : in_i[i];
    end
  end

  always_comb begin
    first_one_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (scan[i]) first_one_o = CW'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

module gcd_stein_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] gcd_o,
  output logic             busy_o
);

  localparam int KW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHARED = 3'd1;
  localparam logic [2:0] S_NORM_A = 3'd2;
  localparam logic [2:0] S_NORM_B = 3'd3;
  localparam logic [2:0] S_SUB    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // state_q is the observable FSM state for checkers.
  logic [2:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] gcd_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] tz_in;
  logic [KW-1:0]    tz_cnt;
  logic             tz_none;
  logic             tz_used;

  logic [WIDTH-1:0] sub_lo;
  logic [WIDTH-1:0] sub_hi;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_equal;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its payload stable until then.
  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign gcd_o       = gcd_q;
  assign busy_o      = (state_q != S_IDLE);

  always_comb begin
    tz_in   = '0;
    tz_used = 1'b0;
    case (state_q)
      S_SHARED: begin tz_in = a_q | b_q; tz_used = 1'b1; end
      S_NORM_A: begin tz_in = a_q;       tz_used = 1'b1; end
      S_NORM_B: begin tz_in = b_q;       tz_used = 1'b1; end
      default:  begin tz_in = '0;        tz_used = 1'b0; end
    endcase
  end

  find_first_one #(
    .WIDTH (WIDTH),
    .FLIP  (1'b0)
  ) u_tz (
    .in_i        (tz_in),
    .first_one_o (tz_cnt),
    .no_ones_o   (tz_none)
  );

  // Both operands are odd in SUB, so the difference is even or zero.
  always_comb begin
    sub_lo    = (a_q < b_q) ? a_q : b_q;
    sub_hi    = (a_q < b_q) ? b_q : a_q;
    sub_diff  = sub_hi - sub_lo;
    sub_equal = (a_q == b_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      gcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_q <= a_i;
            b_q <= b_i;
            if ((a_i == '0) || (b_i == '0)) begin
              gcd_q       <= a_i | b_i;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_SHARED;
            end
          end
        end
        S_SHARED: begin
          k_q     <= tz_cnt;
          state_q <= S_NORM_A;
        end
        S_NORM_A: begin
          a_q     <= a_q >> tz_cnt;
          state_q <= S_NORM_B;
        end
        S_NORM_B: begin
          b_q     <= b_q >> tz_cnt;
          state_q <= S_SUB;
        end
        S_SUB: begin
          a_q <= sub_lo;
          b_q <= sub_diff;
          if (sub_equal) begin
            gcd_q       <= sub_lo << k_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_NORM_B;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tz_input_nonzero: assert (!(tz_used && tz_none));
    end
  end
`endif

endmodule

// File: tb/tb_gcd_stein_ctrl.sv
// Bench for gcd_stein_ctrl: directed scenarios plus a random regression
// scored against a Euclid reference and the Stein latency formula.

module tb_gcd_stein_ctrl;

  localparam int W    = 32;
  localparam int WDOG = 4 * W + 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] gcd;
  logic         busy;

  int errors;
  int checks;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  gcd_stein_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .gcd_o       (gcd),
    .busy_o      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int stein_lat(logic [W-1:0] a, logic [W-1:0] b);
    int n;
    logic [W-1:0] lo, hi;
    if (a == '0 || b == '0) return 1;
    n = 0;
    while (a[0] == 1'b0) a = a >> 1;
    while (b[0] == 1'b0) b = b >> 1;
    forever begin
      n++;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (hi == lo) break;
      a = lo;
      b = hi - lo;
      while (b[0] == 1'b0) b = b >> 1;
    end
    return 3 + 2 * n;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(1, 1000));
      3:       return W'($urandom) << $urandom_range(0, 24);
      default: return W'($urandom);
    endcase
  endfunction

  // driver: one full job, accept through output handshake
  task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit rand_rdy, input bit poke,
                        output logic [W-1:0] got, output int lat,
                        output bit to, output bit unstable);
    int waited;
    got = '0; lat = 0; to = 1'b0; unstable = 1'b0; waited = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : (stall == 0);
    @(posedge clk);
    exp_q.push_back(ref_gcd(a, b));
    lat_q.push_back(stein_lat(a, b));
    forever begin
      #1;
      lat++;
      if (out_valid) break;
      if (lat >= WDOG) begin to = 1'b1; break; end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : (stall == 0);
      @(posedge clk);
    end
    if (to) begin
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    got = gcd;
    forever begin
      @(negedge clk);
      in_valid = poke;
      if (poke) begin
        a_in = ~a;
        b_in = b + 1;
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : (waited >= stall);
      if (out_ready) begin
        in_valid = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (out_valid !== 1'b1 || gcd !== got || in_ready !== 1'b0) unstable = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (gcd !== '0) begin errors++; $display("FAIL reset_gcd got=%0h exp=0", gcd); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] got, exp; int lat, exp_lat; bit to, unst;
    do_job(32'd12, 32'd18, 0, 1'b0, 1'b0, got, lat, to, unst);
    exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
    checks++; if (to || got !== exp) begin errors++; $display("FAIL basic_gcd got=%0d exp=%0d", got, exp); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL basic_latency_model got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] za[3];
    logic [W-1:0] zb[3];
    logic [W-1:0] zr[3];
    logic [W-1:0] got, exp; int lat, exp_lat; bit to, unst;
    za[0] = 32'd0;  zb[0] = 32'd35; zr[0] = 32'd35;
    za[1] = 32'd40; zb[1] = 32'd0;  zr[1] = 32'd40;
    za[2] = 32'd0;  zb[2] = 32'd0;  zr[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      do_job(za[i], zb[i], 0, 1'b0, 1'b0, got, lat, to, unst);
      exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
      checks++; if (to || got !== zr[i] || got !== exp) begin
        errors++; $display("FAIL zero_gcd[%0d] got=%0d exp=%0d", i, got, zr[i]);
      end
      checks++; if (lat !== 1 || lat !== exp_lat) begin
        errors++; $display("FAIL zero_latency[%0d] got=%0d exp=1", i, lat);
      end
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] got, exp; int lat, exp_lat; bit to, unst;
    do_job(32'h8000_0000, 32'h4000_0000, 0, 1'b0, 1'b0, got, lat, to, unst);
    exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
    checks++; if (to || got !== 32'h4000_0000 || got !== exp) begin errors++; $display("FAIL pow2_gcd got=%0h exp=40000000", got); end
    checks++; if (lat !== 5 || lat !== exp_lat) begin errors++; $display("FAIL pow2_latency got=%0d exp=5", lat); end
    do_job(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0, 1'b0, got, lat, to, unst);
    exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
    checks++; if (to || got !== 32'd1 || got !== exp) begin errors++; $display("FAIL ones_gcd got=%0h exp=1 timeout=%0b", got, to); end
    checks++; if (lat !== exp_lat || lat > WDOG) begin errors++; $display("FAIL ones_latency got=%0d exp=%0d", lat, exp_lat); end
    do_job(32'd7, 32'd7, 0, 1'b0, 1'b0, got, lat, to, unst);
    exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
    checks++; if (to || got !== 32'd7 || got !== exp) begin errors++; $display("FAIL equal_gcd got=%0d exp=7", got); end
    checks++; if (lat !== 5 || lat !== exp_lat) begin errors++; $display("FAIL equal_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got, exp; int lat, exp_lat; bit to, unst;
    do_job(32'd48, 32'd180, 10, 1'b0, 1'b1, got, lat, to, unst);
    exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
    checks++; if (to || got !== 32'd12 || got !== exp) begin errors++; $display("FAIL bp_gcd got=%0d exp=12", got); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (unst !== 1'b0) begin errors++; $display("FAIL bp_stable got_unstable=%0b exp=0", unst); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_poke_ignored busy=%0b out_valid=%0b exp 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_job();
    logic [W-1:0] got, exp; int lat, exp_lat; bit to, unst; bit seen;
    @(negedge clk);
    in_valid = 1'b1; a_in = 32'd1071; b_in = 32'd462; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_immediate out_valid=%0b in_ready=%0b busy=%0b exp 0/1/0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got_valid=%0b exp=0", seen); end
    do_job(32'd1071, 32'd462, 0, 1'b0, 1'b0, got, lat, to, unst);
    exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
    checks++; if (to || got !== 32'd21 || got !== exp) begin errors++; $display("FAIL midrst_rerun_gcd got=%0d exp=21", got); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL midrst_rerun_latency got=%0d exp=%0d", lat, exp_lat); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, got, exp; int lat, exp_lat; bit to, unst;
    for (int n = 0; n < 600; n++) begin
      a = rand_op();
      b = rand_op();
      do_job(a, b, 0, 1'b1, 1'b0, got, lat, to, unst);
      exp = exp_q.pop_front(); exp_lat = lat_q.pop_front();
      checks++; if (to || got !== exp) begin
        errors++; $display("FAIL rand_gcd a=%0h b=%0h got=%0h exp=%0h timeout=%0b", a, b, got, exp, to);
      end
      checks++; if (lat !== exp_lat || lat > WDOG) begin
        errors++; $display("FAIL rand_latency a=%0h b=%0h got=%0d exp=%0d", a, b, lat, exp_lat);
      end
      checks++; if (unst !== 1'b0) begin
        errors++; $display("FAIL rand_stable a=%0h b=%0h got_unstable=%0b exp=0", a, b, unst);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_zero();
    test_extremes();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
